// File: rtl/regfile_arbiter.sv
// Two-requester (core, debug) front end for a 2-read/1-write register file.
// Reads take one register-file cycle; writes hold address/data around a one-cycle write pulse.
module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            reqValid,
  output logic [1:0]            reqReady,
  input  logic [1:0]            reqWe,
  input  logic [2*ADDR_W-1:0]   reqAddrA,
  input  logic [2*ADDR_W-1:0]   reqAddrB,
  input  logic [2*ADDR_W-1:0]   reqAddrD,
  input  logic [2*DATA_W-1:0]   reqData,
  output logic [1:0]            rspValid,
  output logic [DATA_W-1:0]     rspA,
  output logic [DATA_W-1:0]     rspB,
  output logic [ADDR_W-1:0]     regAddrA,
  output logic [ADDR_W-1:0]     regAddrB,
  output logic [ADDR_W-1:0]     regAddrD,
  output logic                  regReA,
  output logic                  regReB,
  output logic                  regWeD,
  input  logic [DATA_W-1:0]     busA,
  input  logic [DATA_W-1:0]     busB,
  output logic [DATA_W-1:0]     busD
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RESP
  } StateT;

  StateT state;
  logic  lastGrant;
  logic  grantSel;

  logic              grantCore;
  logic              grantDbg;
  logic              sel;
  logic              selWe;
  logic [ADDR_W-1:0] selA;
  logic [ADDR_W-1:0] selB;
  logic [ADDR_W-1:0] selD;
  logic [DATA_W-1:0] selData;

  // Round-robin pick (lastGrant = 1 means debug won last) and the chosen requester's fields.
  always_comb begin
    grantCore = reqValid[0] && (!reqValid[1] || lastGrant);
    grantDbg  = reqValid[1] && !grantCore;
    sel       = grantDbg;
    selWe     = sel ? reqWe[1] : reqWe[0];
    selA      = sel ? reqAddrA[ADDR_W +: ADDR_W] : reqAddrA[0 +: ADDR_W];
    selB      = sel ? reqAddrB[ADDR_W +: ADDR_W] : reqAddrB[0 +: ADDR_W];
    selD      = sel ? reqAddrD[ADDR_W +: ADDR_W] : reqAddrD[0 +: ADDR_W];
    selData   = sel ? reqData[DATA_W +: DATA_W] : reqData[0 +: DATA_W];
    reqReady  = 2'b00;
    if (state == IDLE && !rst) begin
      reqReady = {grantDbg, grantCore};
    end
  end

  // The output registers double as the latched request; the requester is free after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      grantSel  <= 1'b0;
      rspValid  <= 2'b00;
      rspA      <= '0;
      rspB      <= '0;
      regAddrA  <= '0;
      regAddrB  <= '0;
      regAddrD  <= '0;
      regReA    <= 1'b0;
      regReB    <= 1'b0;
      regWeD    <= 1'b0;
      busD      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantCore || grantDbg) begin
            lastGrant <= sel;
            grantSel  <= sel;
            if (!selWe) begin
              state    <= READ;
              regReA   <= 1'b1;
              regReB   <= 1'b1;
              regAddrA <= selA;
              regAddrB <= selB;
            end else if (selD != '0) begin
              state    <= WR_SETUP;
              regAddrD <= selD;
              busD     <= selData;
            end else begin
              state    <= RESP;
              rspValid <= {sel, ~sel};
              rspA     <= '0;
              rspB     <= '0;
            end
          end
        end
        READ: begin
          // Register 0 reads as zero whatever the bus carries.
          rspA     <= (regAddrA == '0) ? '0 : busA;
          rspB     <= (regAddrB == '0) ? '0 : busB;
          rspValid <= {grantSel, ~grantSel};
          regReA   <= 1'b0;
          regReB   <= 1'b0;
          regAddrA <= '0;
          regAddrB <= '0;
          state    <= RESP;
        end
        WR_SETUP: begin
          regWeD <= 1'b1;
          state  <= WR_PULSE;
        end
        WR_PULSE: begin
          regWeD <= 1'b0;
          state  <= WR_HOLD;
        end
        WR_HOLD: begin
          regAddrD <= '0;
          busD     <= '0;
          rspValid <= {grantSel, ~grantSel};
          rspA     <= '0;
          rspB     <= '0;
          state    <= RESP;
        end
        RESP: begin
          rspValid <= 2'b00;
          rspA     <= '0;
          rspB     <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter: a small register-file memory answers the DUT's
// bus, and a separate expected-contents array predicts every response.
module tb_regfile_arbiter;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    reqValid;
  logic [1:0]    reqReady;
  logic [1:0]    reqWe;
  logic [2*AW-1:0] reqAddrA, reqAddrB, reqAddrD;
  logic [2*DW-1:0] reqData;
  logic [1:0]    rspValid;
  logic [DW-1:0] rspA, rspB;
  logic [AW-1:0] regAddrA, regAddrB, regAddrD;
  logic          regReA, regReB, regWeD;
  logic [DW-1:0] busA, busB, busD;

  logic [DW-1:0] tbMem [32];
  logic [DW-1:0] model [32];

  int total = 0;
  int bad   = 0;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWe(reqWe),
    .reqAddrA(reqAddrA), .reqAddrB(reqAddrB), .reqAddrD(reqAddrD), .reqData(reqData),
    .rspValid(rspValid), .rspA(rspA), .rspB(rspB),
    .regAddrA(regAddrA), .regAddrB(regAddrB), .regAddrD(regAddrD),
    .regReA(regReA), .regReB(regReB), .regWeD(regWeD),
    .busA(busA), .busB(busB), .busD(busD)
  );

  always #5 clk = ~clk;

  // Register file stand-in: write commits on the clock edge ending the pulse, unless reset.
  assign busA = tbMem[regAddrA];
  assign busB = tbMem[regAddrB];
  always @(posedge clk) begin
    if (regWeD && !rst) tbMem[regAddrD] <= busD;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetDut();
    rst = 1'b1;
    reqValid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issues one request and follows it to its response; returns cycles spent waiting for ready.
  task automatic runOp(input int who, input logic we, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic [DW-1:0] data, output int waitCycles);
    logic [1:0]    oh;
    int            expLat;
    logic [DW-1:0] expA, expB;
    oh = (who == 1) ? 2'b10 : 2'b01;
    reqValid = oh;
    reqWe[who] = we;
    reqAddrA[who*AW +: AW] = a;
    reqAddrB[who*AW +: AW] = b;
    reqAddrD[who*AW +: AW] = d;
    reqData[who*DW +: DW] = data;
    waitCycles = 0;
    #1;
    while (reqReady !== oh && waitCycles < 20) begin
      @(posedge clk);
      #2;
      waitCycles++;
    end
    total++;
    if (reqReady !== oh) begin
      bad++;
      $display("[TB] FAIL grant wait: got reqReady=%b expected %b", reqReady, oh);
      reqValid = 2'b00;
      return;
    end
    expA = (a == 0) ? '0 : model[a];
    expB = (b == 0) ? '0 : model[b];
    if (!we) expLat = 2;
    else if (d == 0) expLat = 1;
    else expLat = 4;
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    reqWe    = 2'($urandom);
    reqAddrA = (2*AW)'($urandom);
    reqAddrB = (2*AW)'($urandom);
    reqAddrD = (2*AW)'($urandom);
    reqData  = (2*DW)'($urandom);
    for (int k = 1; k <= expLat; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      total++;
      if (rspValid !== ((k == expLat) ? oh : 2'b00)) begin
        bad++;
        $display("[TB] FAIL rspValid step %0d: got %b expected %b", k, rspValid, (k == expLat) ? oh : 2'b00);
      end
      if (!we && k == 1) begin
        total++;
        if ({regReA, regReB, regAddrA, regAddrB} !== {1'b1, 1'b1, a, b}) begin
          bad++;
          $display("[TB] FAIL read port: got re=%b%b a=%0d b=%0d expected re=11 a=%0d b=%0d",
                   regReA, regReB, regAddrA, regAddrB, a, b);
        end
      end
      if (we && d != 0 && k <= 3) begin
        total++;
        if ({regWeD, regAddrD, busD} !== {(k == 2), d, data}) begin
          bad++;
          $display("[TB] FAIL write port step %0d: got we=%b d=%0d data=%h expected we=%b d=%0d data=%h",
                   k, regWeD, regAddrD, busD, (k == 2), d, data);
        end
      end
      if (k == expLat) begin
        total++;
        if (we) begin
          expA = '0;
          expB = '0;
        end
        if ({rspA, rspB} !== {expA, expB}) begin
          bad++;
          $display("[TB] FAIL response data: got %h/%h expected %h/%h", rspA, rspB, expA, expB);
        end
        total++;
        if ({regReA, regReB, regWeD, regAddrA, regAddrB, regAddrD} !== '0) begin
          bad++;
          $display("[TB] FAIL idle ports in resp: got re=%b%b we=%b addr=%0d/%0d/%0d expected all 0",
                   regReA, regReB, regWeD, regAddrA, regAddrB, regAddrD);
        end
      end
    end
    if (we && d != 0) model[d] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 2'b11;
    reqWe = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({reqReady, rspValid, regReA, regReB, regWeD, regAddrA, regAddrB, regAddrD, busD, rspA, rspB} !== '0) begin
      bad++;
      $display("[TB] FAIL reset outputs: got ready=%b rsp=%b re=%b%b we=%b busD=%h rspA=%h expected all 0",
               reqReady, rspValid, regReA, regReB, regWeD, busD, rspA);
    end
    reqValid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_core_read();
    int w;
    runOp(0, 1'b0, 5'd3, 5'd0, 5'($urandom), 16'($urandom), w);
  endtask

  task automatic test_debug_write();
    int w;
    runOp(1, 1'b1, 5'($urandom), 5'($urandom), 5'd5, 16'd14, w);
    runOp(0, 1'b0, 5'd5, 5'd3, 5'd0, 16'd0, w);
  endtask

  task automatic test_write_zero();
    int w;
    runOp(0, 1'b1, 5'd1, 5'd2, 5'd0, 16'hBEEF, w);
    runOp(1, 1'b0, 5'd0, 5'd0, 5'd0, 16'd0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    runOp(1, 1'b0, 5'd4, 5'd6, 5'd0, 16'd0, w);
    runOp(0, 1'b1, 5'd0, 5'd0, 5'd9, 16'($urandom), w);
    total++;
    if (w !== 1) begin
      bad++;
      $display("[TB] FAIL back-to-back gap: got %0d expected 1", w);
    end
  endtask

  task automatic test_arbitration();
    int   expWho;
    int   grants;
    logic [1:0] expOh;
    resetDut();
    reqWe = 2'b00;
    reqAddrA = (2*AW)'($urandom);
    reqAddrB = (2*AW)'($urandom);
    reqValid = 2'b11;
    expWho = 0;
    grants = 0;
    #1;
    for (int c = 0; c < 24; c++) begin
      total++;
      if ($countones(reqReady) > 1) begin
        bad++;
        $display("[TB] FAIL one-hot ready: got %b expected at most one bit", reqReady);
      end
      if (reqReady != 2'b00) begin
        expOh = (expWho == 1) ? 2'b10 : 2'b01;
        total++;
        if (reqReady !== expOh) begin
          bad++;
          $display("[TB] FAIL round robin grant %0d: got %b expected %b", grants, reqReady, expOh);
        end
        expWho ^= 1;
        grants++;
      end
      @(posedge clk);
      #2;
    end
    reqValid = 2'b00;
    total++;
    if (grants !== 8) begin
      bad++;
      $display("[TB] FAIL grant count: got %0d expected 8", grants);
    end
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_write();
    int   sawRsp;
    logic [DW-1:0] data;
    resetDut();
    data = 16'($urandom) | 16'h1;
    if (data == model[7]) data = ~data;
    reqValid = 2'b01;
    reqWe = 2'b01;
    reqAddrD[0 +: AW] = 5'd7;
    reqData[0 +: DW] = data;
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    @(posedge clk);
    #1;
    total++;
    if (regWeD !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pulse before abort: got %b expected 1", regWeD);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({regWeD, rspValid} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL abort write: got we=%b rsp=%b expected 0/00", regWeD, rspValid);
    end
    sawRsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (rspValid != 2'b00) sawRsp++;
    end
    total++;
    if (sawRsp !== 0) begin
      bad++;
      $display("[TB] FAIL aborted write response: got %0d pulses expected 0", sawRsp);
    end
    total++;
    if (tbMem[7] !== model[7]) begin
      bad++;
      $display("[TB] FAIL aborted write landed: got %h expected %h", tbMem[7], model[7]);
    end
    reqValid = 2'b01;
    reqWe = 2'b00;
    #1;
    total++;
    if (reqReady !== 2'b01) begin
      bad++;
      $display("[TB] FAIL idle after abort: got reqReady=%b expected 01", reqReady);
    end
    reqValid = 2'b00;
  endtask

  task automatic test_reset_mid_read();
    int sawRsp;
    @(posedge clk);
    #1;
    reqValid = 2'b10;
    reqWe = 2'b00;
    reqAddrA[AW +: AW] = 5'd3;
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sawRsp = 0;
    for (int c = 0; c < 4; c++) begin
      if (rspValid != 2'b00) sawRsp++;
      @(posedge clk);
      #1;
    end
    total++;
    if (sawRsp !== 0) begin
      bad++;
      $display("[TB] FAIL aborted read response: got %0d pulses expected 0", sawRsp);
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 40; i++) begin
      runOp(int'($urandom_range(0, 1)), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 16'($urandom), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    rst = 1'b1;
    reqValid = 2'b00;
    reqWe = 2'b00;
    reqAddrA = '0;
    reqAddrB = '0;
    reqAddrD = '0;
    reqData = '0;
    for (int i = 0; i < 32; i++) begin
      v = 16'($urandom);
      tbMem[i] = v;
      model[i] = v;
    end
    tbMem[0] = 16'hFFFF;
    model[0] = 16'hFFFF;
    tbMem[3] = 16'h1234;
    model[3] = 16'h1234;
    #1;
    test_reset();
    test_core_read();
    test_debug_write();
    test_write_zero();
    test_back_to_back();
    test_arbitration();
    test_reset_mid_write();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: register width; all bus and data ports are DATA_W bits.
REQ-002 Parameter ADDR_W, default 5: register address width (32 registers).
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 rst  in  1: synchronous, active-high reset.
REQ-005 reqValid  in  2: per-requester request valid; bit0 = core, bit1 = debug.
REQ-006 reqReady  out  2: per-requester accept strobe; a request transfers when reqValid[i] and reqReady[i] are both high.
REQ-007 reqWe  in  2: per requester, 1 = write op, 0 = read-pair op.
REQ-008 reqAddrA, reqAddrB, reqAddrD  in  2*ADDR_W each: per-requester addresses, requester i in slice [i*ADDR_W +: ADDR_W].
REQ-009 reqData  in  2*DATA_W: per-requester write data, same slicing.
REQ-010 rspValid  out  2: one-hot completion pulse, one cycle, for the granted requester.
REQ-011 rspA, rspB  out  DATA_W each: read operands; valid only while rspValid != 0.
REQ-012 regAddrA, regAddrB, regAddrD  out  ADDR_W each: register-file addresses.
REQ-013 regReA, regReB, regWeD  out  1 each: register-file read enables and write enable.
REQ-014 busA, busB  in  DATA_W each: register-file read data.
REQ-015 busD  out  DATA_W: register-file write data.

Function
REQ-016 FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
REQ-017 reqReady is driven only in IDLE; at most one bit high; no bit high outside IDLE.
REQ-018 Arbitration in IDLE: single valid -> grant it; both valid -> grant the requester not granted last (round-robin); last-grant pointer resets to debug, so core wins the first tie after reset.
REQ-019 On grant: latch we, addresses and data into internal registers; the requester may change its inputs from the next cycle.
REQ-020 Granted read: IDLE -> READ -> RESP -> IDLE.
REQ-021 In READ: regReA = regReB = 1, regAddrA/B = latched addresses; busA/busB captured at the end of the cycle.
REQ-022 Granted write with address != 0: IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> RESP -> IDLE.
REQ-023 regAddrD and busD are held at the latched values across WR_SETUP, WR_PULSE and WR_HOLD.
REQ-024 regWeD = 1 only in WR_PULSE, so its falling edge (the commit point) occurs with address and data stable one cycle before and after.
REQ-025 Granted write with address 0: IDLE -> RESP directly; regWeD is never asserted.
REQ-026 In RESP: rspValid[granted] = 1 for exactly one cycle; for reads rspA/rspB = captured operands; for writes rspA/rspB = 0.
REQ-027 A read of address 0 on either port returns 0 on that port regardless of bus contents.
REQ-028 Latency, accept cycle N: read rspValid at N+2; write (nonzero address) at N+4; write to address 0 at N+1.
REQ-029 Outside their active states: regReA, regReB, regWeD = 0, and all reg address outputs = 0.
REQ-030 The next grant is possible in the IDLE cycle after RESP; back-to-back requests therefore have a 1-cycle gap.

Reset
REQ-031 rst high: state -> IDLE; reqReady, rspValid, regReA, regReB, regWeD = 0; all address, data and response outputs = 0; last-grant = debug.
REQ-032 Reset mid-write: regWeD drops to 0 the next cycle and the write is abandoned; no rspValid is issued for the aborted operation.
REQ-033 Reset mid-read: the pending response is discarded.

Verification
REQ-034 Core read: A=3, B=0 with busA=0x1234 and busB=0xFFFF -> regReA/B high one cycle, then rspValid=01, rspA=0x1234, rspB=0 at N+2.
REQ-035 Debug write: D=5, data=14 -> regWeD high exactly one cycle in WR_PULSE, regAddrD=5 and busD=14 stable from setup through hold, rspValid=10 at N+4.
REQ-036 Write to address 0 -> regWeD stays 0 throughout; rspValid at N+1.
REQ-037 Both valid continuously from reset -> grants alternate core, debug, core, debug; never two reqReady bits high at once.
REQ-038 rst asserted during WR_PULSE -> regWeD = 0 the next cycle, state IDLE, no rspValid.
REQ-039 Requester changes addresses and data the cycle after accept -> the regfile outputs still carry the latched values.
